// File: rtl/fx3_slave_fifo_emu.sv
// -----------------------------------------------------------------------------
// fx3_slave_fifo_emu
//
// Behavioural-but-synthesizable stand-in for the FX3 synchronous slave FIFO
// interface, as seen from the FPGA master. Two socket buffers are modelled:
//   IN  socket : FPGA writes (ADDR=2'b00), host side drains it.
//   OUT socket : host side fills it, FPGA reads (ADDR=2'b11).
//
// Ports
//   clk_pll, reset          single clock, synchronous active-high reset
//   SLCS, ADDR, SLRD, SLWR  bus chip select / socket select / strobes (active low)
//   SLOE, PKEND             output enable / packet end (active low)
//   dq_in, dq_out, dq_oe    32-bit data bus halves and driver enable
//   FLAGA..FLAGD            registered IN not-full / IN space > WATERMARK /
//                           OUT not-empty / OUT occupancy > WATERMARK
//   host_wr_*               valid/ready stream filling the OUT socket
//   host_rd_*               valid/ready stream draining the IN socket (FWFT)
//   ovf_err, unf_err,       sticky: write to full IN socket, read from empty
//   addr_err                OUT socket, strobe aimed at the wrong/illegal socket
//
// Read path: a word popped at edge N reaches dq_out at edge N+2. The popped
// word passes through two pipeline stages and then loads dq_out, which holds
// its value whenever the slot reaching it carries no read.
// -----------------------------------------------------------------------------
module fx3_slave_fifo_emu #(
    parameter int DEPTH     = 32,
    parameter int WATERMARK = 4
) (
    input  logic        clk_pll,
    input  logic        reset,
    input  logic        SLCS,
    input  logic [1:0]  ADDR,
    input  logic        SLRD,
    input  logic        SLWR,
    input  logic        SLOE,
    input  logic        PKEND,
    input  logic [31:0] dq_in,
    output logic [31:0] dq_out,
    output logic        dq_oe,
    output logic        FLAGA,
    output logic        FLAGB,
    output logic        FLAGC,
    output logic        FLAGD,
    input  logic        host_wr_valid,
    output logic        host_wr_ready,
    input  logic [31:0] host_wr_data,
    output logic        host_rd_valid,
    input  logic        host_rd_ready,
    output logic [31:0] host_rd_data,
    output logic        host_rd_last,
    output logic        ovf_err,
    output logic        unf_err,
    output logic        addr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] WM_CNT   = CW'(WATERMARK);

    localparam logic [1:0] SOCK_IN  = 2'b00;
    localparam logic [1:0] SOCK_OUT = 2'b11;

    // Socket storage: IN words carry the packet-end marker in bit 32.
    logic [32:0]   in_mem  [DEPTH];
    logic [31:0]   out_mem [DEPTH];

    logic [AW-1:0] in_wr_ptr, in_rd_ptr, out_wr_ptr, out_rd_ptr;
    logic [CW-1:0] in_cnt, out_cnt, in_cnt_nxt, out_cnt_nxt;

    logic          rd_p1_vld, rd_p2_vld;
    logic [31:0]   rd_p1_dat, rd_p2_dat;

    logic          rd_stb, wr_stb;
    logic          bus_rd, bus_wr, bad_addr;
    logic          in_full, in_empty, out_full, out_empty;
    logic          in_push, in_pop, out_push, out_pop;
    logic [32:0]   in_head;

    // ---------------- bus decode ----------------
    assign rd_stb = ~SLCS & ~SLRD;
    assign wr_stb = ~SLCS & ~SLWR;

    assign bus_wr = wr_stb & (ADDR == SOCK_IN);
    assign bus_rd = rd_stb & (ADDR == SOCK_OUT);

    // A strobe is illegal when it targets a reserved address or the socket
    // whose direction does not match it. With both strobes low, the strobe
    // that matches ADDR still transfers while the other one flags an error.
    assign bad_addr = ((rd_stb | wr_stb) & (ADDR != SOCK_IN) & (ADDR != SOCK_OUT))
                    | (wr_stb & (ADDR == SOCK_OUT))
                    | (rd_stb & (ADDR == SOCK_IN));

    // ---------------- occupancy / handshakes ----------------
    assign in_full   = (in_cnt  == FULL_CNT);
    assign in_empty  = (in_cnt  == '0);
    assign out_full  = (out_cnt == FULL_CNT);
    assign out_empty = (out_cnt == '0);

    // Host handshakes are held low while reset is applied.
    assign host_wr_ready = ~reset & ~out_full;
    assign host_rd_valid = ~reset & ~in_empty;

    assign in_push  = bus_wr & ~in_full;
    assign in_pop   = host_rd_valid & host_rd_ready;
    assign out_push = host_wr_valid & host_wr_ready;
    assign out_pop  = bus_rd & ~out_empty;

    assign in_head      = in_mem[in_rd_ptr];
    assign host_rd_data = in_head[31:0];
    assign host_rd_last = in_head[32];

    always_comb begin
        // NOTE: defaults first, so every path assigns these and no latch is inferred.
        in_cnt_nxt  = in_cnt;
        out_cnt_nxt = out_cnt;
        if (in_push && !in_pop) begin
            in_cnt_nxt = in_cnt + CW'(1);
        end else if (!in_push && in_pop) begin
            in_cnt_nxt = in_cnt - CW'(1);
        end
        if (out_push && !out_pop) begin
            out_cnt_nxt = out_cnt + CW'(1);
        end else if (!out_push && out_pop) begin
            out_cnt_nxt = out_cnt - CW'(1);
        end
    end

    // ---------------- storage ----------------
    // NOTE: the arrays are not reset; pointers and counts alone decide which entries are valid.
    always_ff @(posedge clk_pll) begin
        if (in_push) begin
            in_mem[in_wr_ptr] <= {~PKEND, dq_in};
        end
        if (out_push) begin
            out_mem[out_wr_ptr] <= host_wr_data;
        end
    end

    // ---------------- control state ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_pll) begin
        if (reset) begin
            in_wr_ptr  <= '0;
            in_rd_ptr  <= '0;
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            in_cnt     <= '0;
            out_cnt    <= '0;
            rd_p1_vld  <= 1'b0;
            rd_p1_dat  <= '0;
            rd_p2_vld  <= 1'b0;
            rd_p2_dat  <= '0;
            dq_out     <= '0;
            dq_oe      <= 1'b0;
            FLAGA      <= 1'b0;
            FLAGB      <= 1'b0;
            FLAGC      <= 1'b0;
            FLAGD      <= 1'b0;
            ovf_err    <= 1'b0;
            unf_err    <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            if (in_push)  in_wr_ptr  <= in_wr_ptr  + AW'(1);
            if (in_pop)   in_rd_ptr  <= in_rd_ptr  + AW'(1);
            if (out_push) out_wr_ptr <= out_wr_ptr + AW'(1);
            if (out_pop)  out_rd_ptr <= out_rd_ptr + AW'(1);
            in_cnt  <= in_cnt_nxt;
            out_cnt <= out_cnt_nxt;

            // Read pipeline advances every cycle; only valid slots load dq_out.
            rd_p1_vld <= out_pop;
            rd_p1_dat <= out_mem[out_rd_ptr];
            rd_p2_vld <= rd_p1_vld;
            rd_p2_dat <= rd_p1_dat;
            if (rd_p2_vld) begin
                dq_out <= rd_p2_dat;
            end

            dq_oe <= ~SLCS & ~SLOE;

            // Flags reflect the occupancy after this edge's push/pop.
            FLAGA <= (in_cnt_nxt < FULL_CNT);
            FLAGB <= ((FULL_CNT - in_cnt_nxt) > WM_CNT);
            FLAGC <= (out_cnt_nxt != '0);
            FLAGD <= (out_cnt_nxt > WM_CNT);

            ovf_err  <= ovf_err  | (bus_wr & in_full);
            unf_err  <= unf_err  | (bus_rd & out_empty);
            addr_err <= addr_err | bad_addr;
        end
    end

endmodule

// File: tb/tb_fx3_slave_fifo_emu.sv
// -----------------------------------------------------------------------------
// tb_fx3_slave_fifo_emu
//
// Directed scenarios followed by randomized bus/host traffic. A queue-based
// reference model is advanced at every rising edge and all outputs are
// compared against it on the falling edge; directed scenarios additionally
// check fixed expected constants.
// -----------------------------------------------------------------------------
module tb_fx3_slave_fifo_emu;

    localparam int DEPTH = 32;
    localparam int WM    = 4;

    logic        clk_pll = 1'b0;
    logic        reset;
    logic        SLCS, SLRD, SLWR, SLOE, PKEND;
    logic [1:0]  ADDR;
    logic [31:0] dq_in;
    logic [31:0] dq_out;
    logic        dq_oe;
    logic        FLAGA, FLAGB, FLAGC, FLAGD;
    logic        host_wr_valid, host_wr_ready;
    logic [31:0] host_wr_data;
    logic        host_rd_valid, host_rd_ready;
    logic [31:0] host_rd_data;
    logic        host_rd_last;
    logic        ovf_err, unf_err, addr_err;

    always #5 clk_pll = ~clk_pll;

    fx3_slave_fifo_emu #(.DEPTH(DEPTH), .WATERMARK(WM)) dut (
        .clk_pll       (clk_pll),
        .reset         (reset),
        .SLCS          (SLCS),
        .ADDR          (ADDR),
        .SLRD          (SLRD),
        .SLWR          (SLWR),
        .SLOE          (SLOE),
        .PKEND         (PKEND),
        .dq_in         (dq_in),
        .dq_out        (dq_out),
        .dq_oe         (dq_oe),
        .FLAGA         (FLAGA),
        .FLAGB         (FLAGB),
        .FLAGC         (FLAGC),
        .FLAGD         (FLAGD),
        .host_wr_valid (host_wr_valid),
        .host_wr_ready (host_wr_ready),
        .host_wr_data  (host_wr_data),
        .host_rd_valid (host_rd_valid),
        .host_rd_ready (host_rd_ready),
        .host_rd_data  (host_rd_data),
        .host_rd_last  (host_rd_last),
        .ovf_err       (ovf_err),
        .unf_err       (unf_err),
        .addr_err      (addr_err)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    logic [32:0] m_in  [$];   // {last, data}
    logic [31:0] m_out [$];
    bit          p1_v, p2_v;
    logic [31:0] p1_d, p2_d;
    logic [31:0] m_dq;
    bit          m_oe, m_fa, m_fb, m_fc, m_fd, m_ovf, m_unf, m_addr;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int in_n, out_n;
        bit cs, rd, wr;
        if (reset) begin
            m_in.delete();
            m_out.delete();
            p1_v = 0; p2_v = 0; p1_d = '0; p2_d = '0;
            m_dq = '0; m_oe = 0;
            m_fa = 0; m_fb = 0; m_fc = 0; m_fd = 0;
            m_ovf = 0; m_unf = 0; m_addr = 0;
            return;
        end
        in_n  = m_in.size();
        out_n = m_out.size();
        // two-stage delay line in front of the held output value
        if (p2_v) m_dq = p2_d;
        p2_v = p1_v;
        p2_d = p1_d;
        p1_v = 0;
        cs = !SLCS;
        rd = cs && !SLRD;
        wr = cs && !SLWR;
        if (rd && ADDR == 2'b11) begin
            if (out_n > 0) begin
                p1_v = 1;
                p1_d = m_out.pop_front();
            end else begin
                m_unf = 1;
            end
        end
        if (wr && ADDR == 2'b00) begin
            if (in_n < DEPTH) m_in.push_back({~PKEND, dq_in});
            else              m_ovf = 1;
        end
        if (((rd || wr) && (ADDR == 2'b01 || ADDR == 2'b10)) ||
            (wr && ADDR == 2'b11) || (rd && ADDR == 2'b00))
            m_addr = 1;
        if (host_wr_valid && out_n < DEPTH) m_out.push_back(host_wr_data);
        if (host_rd_ready && in_n > 0) void'(m_in.pop_front());
        m_oe = cs && !SLOE;
        m_fa = (m_in.size() < DEPTH);
        m_fb = ((DEPTH - int'(m_in.size())) > WM);
        m_fc = (m_out.size() > 0);
        m_fd = (m_out.size() > WM);
    endtask

    task automatic check_all();
        check("dq_out",   {1'b0, dq_out},        {1'b0, m_dq});
        check("dq_oe",    {32'b0, dq_oe},        {32'b0, m_oe});
        check("FLAGA",    {32'b0, FLAGA},        {32'b0, m_fa});
        check("FLAGB",    {32'b0, FLAGB},        {32'b0, m_fb});
        check("FLAGC",    {32'b0, FLAGC},        {32'b0, m_fc});
        check("FLAGD",    {32'b0, FLAGD},        {32'b0, m_fd});
        check("wr_ready", {32'b0, host_wr_ready},
              {32'b0, (!reset && m_out.size() < DEPTH)});
        check("rd_valid", {32'b0, host_rd_valid},
              {32'b0, (!reset && m_in.size() > 0)});
        if (!reset && m_in.size() > 0)
            check("rd_head", {host_rd_last, host_rd_data}, m_in[0]);
        check("ovf_err",  {32'b0, ovf_err},      {32'b0, m_ovf});
        check("unf_err",  {32'b0, unf_err},      {32'b0, m_unf});
        check("addr_err", {32'b0, addr_err},     {32'b0, m_addr});
    endtask

    // One clock: model follows the edge, outputs compared mid-cycle.
    task automatic cyc();
        @(posedge clk_pll);
        model_edge();
        @(negedge clk_pll);
        check_all();
    endtask

    task automatic idle();
        SLCS = 1'b1; SLRD = 1'b1; SLWR = 1'b1; SLOE = 1'b1; PKEND = 1'b1;
        ADDR = 2'b00; dq_in = '0;
        host_wr_valid = 1'b0; host_wr_data = '0; host_rd_ready = 1'b0;
    endtask

    task automatic flag_chk(input string tag, input bit a, input bit b, input bit c, input bit d);
        check({tag, "_A"}, {32'b0, FLAGA}, {32'b0, a});
        check({tag, "_B"}, {32'b0, FLAGB}, {32'b0, b});
        check({tag, "_C"}, {32'b0, FLAGC}, {32'b0, c});
        check({tag, "_D"}, {32'b0, FLAGD}, {32'b0, d});
    endtask

    initial begin
        int r;
        bit fill_phase;

        idle();
        reset = 1'b1;

        // ---- reset values ----
        cyc();
        cyc();
        flag_chk("rst", 0, 0, 0, 0);
        check("rst_dq", {1'b0, dq_out}, 33'h0);
        check("rst_wr_ready", {32'b0, host_wr_ready}, 33'h0);
        reset = 1'b0;
        cyc();
        flag_chk("post_rst", 1, 1, 0, 0);

        // ---- host fill, 8 back-to-back FPGA reads ----
        host_wr_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            host_wr_data = 32'h100 + i;
            cyc();
        end
        host_wr_valid = 1'b0;
        SLCS = 1'b0; ADDR = 2'b11; SLRD = 1'b0;
        for (int j = 0; j < 10; j++) begin
            if (j == 8) begin SLRD = 1'b1; SLCS = 1'b1; end
            cyc();
            if (j >= 2) check("burst_dq", {1'b0, dq_out}, 33'(32'h100 + j - 2));
            if (j == 6) check("burst_flagc_one_left", {32'b0, FLAGC}, 33'h1);
            if (j == 7) check("burst_flagc_empty",    {32'b0, FLAGC}, 33'h0);
        end

        // ---- FPGA fills IN socket, overflow, host drain ----
        idle();
        SLCS = 1'b0; ADDR = 2'b00; SLWR = 1'b0;
        for (int i = 0; i < 32; i++) begin
            dq_in = 32'hA000 + i;
            PKEND = (i == 31) ? 1'b0 : 1'b1;
            cyc();
            if (i == 26) check("fill27_flagb", {32'b0, FLAGB}, 33'h1);
            if (i == 27) check("fill28_flagb", {32'b0, FLAGB}, 33'h0);
            if (i == 30) check("fill31_flaga", {32'b0, FLAGA}, 33'h1);
        end
        check("full_flaga", {32'b0, FLAGA}, 33'h0);
        check("full_flagb", {32'b0, FLAGB}, 33'h0);
        check("pre_ovf",    {32'b0, ovf_err}, 33'h0);
        dq_in = 32'hDEAD_BEEF; PKEND = 1'b1;
        cyc();
        check("ovf_set", {32'b0, ovf_err}, 33'h1);
        SLWR = 1'b1; SLCS = 1'b1;
        host_rd_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            check("drain_data", {1'b0, host_rd_data}, 33'(32'hA000 + i));
            check("drain_last", {32'b0, host_rd_last}, {32'b0, (i == 31)});
            cyc();
        end
        host_rd_ready = 1'b0;
        check("drained_valid", {32'b0, host_rd_valid}, 33'h0);

        // ---- watermark on OUT socket ----
        host_wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            host_wr_data = 32'h500 + i;
            cyc();
        end
        host_wr_valid = 1'b0;
        check("wm5_flagd", {32'b0, FLAGD}, 33'h1);
        SLCS = 1'b0; ADDR = 2'b11; SLRD = 1'b0;
        cyc();
        SLRD = 1'b1; SLCS = 1'b1;
        check("wm4_flagd", {32'b0, FLAGD}, 33'h0);
        check("wm4_flagc", {32'b0, FLAGC}, 33'h1);

        // ---- illegal address, then underflow ----
        SLCS = 1'b0; ADDR = 2'b01; SLRD = 1'b0;
        cyc();
        SLRD = 1'b1; SLCS = 1'b1; ADDR = 2'b00;
        check("addr_err_set", {32'b0, addr_err}, 33'h1);
        cyc();
        cyc();
        check("addr_no_pop_dq", {1'b0, dq_out}, 33'h500);
        SLCS = 1'b0; ADDR = 2'b11; SLRD = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        SLRD = 1'b1; SLCS = 1'b1;
        cyc();
        cyc();
        check("addr_next_word", {1'b0, dq_out}, 33'h504);
        check("pre_unf", {32'b0, unf_err}, 33'h0);
        SLCS = 1'b0; ADDR = 2'b11; SLRD = 1'b0;
        cyc();
        SLRD = 1'b1; SLCS = 1'b1;
        check("unf_set", {32'b0, unf_err}, 33'h1);
        for (int i = 0; i < 3; i++) cyc();
        check("unf_dq_hold", {1'b0, dq_out}, 33'h504);

        // ---- simultaneous push/pop at count 3 across the pointer wrap ----
        host_wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            host_wr_data = 32'h700 + i;
            cyc();
        end
        SLCS = 1'b0; ADDR = 2'b11; SLRD = 1'b0;
        for (int k = 0; k < 45; k++) begin
            if (k == 40) host_wr_valid = 1'b0;
            if (k == 43) begin SLRD = 1'b1; SLCS = 1'b1; end
            host_wr_data = 32'h703 + k;
            cyc();
            if (k < 40) begin
                check("steady_flagc", {32'b0, FLAGC}, 33'h1);
                check("steady_flagd", {32'b0, FLAGD}, 33'h0);
            end
            if (k >= 2) check("wrap_dq", {1'b0, dq_out}, 33'(32'h700 + k - 2));
        end

        // ---- reset with words buffered and a read in flight ----
        host_wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            host_wr_data = 32'h800 + i;
            cyc();
        end
        host_wr_valid = 1'b0;
        SLCS = 1'b0; ADDR = 2'b11; SLRD = 1'b0;
        cyc();
        SLRD = 1'b1; SLCS = 1'b1;
        reset = 1'b1;
        cyc();
        flag_chk("midrst", 0, 0, 0, 0);
        check("midrst_dq",       {1'b0, dq_out}, 33'h0);
        check("midrst_wr_ready", {32'b0, host_wr_ready}, 33'h0);
        check("midrst_rd_valid", {32'b0, host_rd_valid}, 33'h0);
        check("midrst_errs",     {30'b0, ovf_err, unf_err, addr_err}, 33'h0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("no_stale_dq", {1'b0, dq_out}, 33'h0);
        end
        flag_chk("post_midrst", 1, 1, 0, 0);

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 3000; n++) begin
            fill_phase = ((n / 300) % 2) == 0;
            reset = ($urandom_range(0, 499) == 0);
            SLCS  = ($urandom_range(0, 7) == 0);
            r = int'($urandom_range(0, 9));
            ADDR  = (r < 4) ? 2'b00 : (r < 8) ? 2'b11 : (r == 8) ? 2'b01 : 2'b10;
            SLWR  = fill_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            SLRD  = fill_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            SLOE  = ($urandom_range(0, 1) == 0);
            PKEND = ($urandom_range(0, 3) != 0);
            dq_in = $urandom;
            host_wr_valid = fill_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            host_wr_data  = $urandom;
            host_rd_ready = fill_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fx3_slave_fifo_emu.md
FX3_SLAVE_FIFO_EMU -- requirements
Module: fx3_slave_fifo_emu

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning words per socket buffer (power of 2, at least 8).
REQ-002 SHALL have parameter WATERMARK, default 4, meaning the partial-flag threshold in words (less than DEPTH).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 Ports, listed as name, direction, width, meaning:
- clk_pll, in, 1: the single clock; every flop samples on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- SLCS, in, 1: chip select, active low.
- ADDR, in, 2: socket select. 2'b11 selects the OUT socket (FPGA reads). 2'b00 selects the IN socket (FPGA writes).
- SLRD, in, 1: read strobe, active low.
- SLWR, in, 1: write strobe, active low.
- SLOE, in, 1: output enable, active low.
- PKEND, in, 1: packet end, active low; qualified by a write.
- dq_in, in, 32: data from the FPGA master.
- dq_out, out, 32: data to the FPGA master.
- dq_oe, out, 1: enables the dq_out driver.
- FLAGA, out, 1: IN socket not full.
- FLAGB, out, 1: IN socket free space greater than WATERMARK.
- FLAGC, out, 1: OUT socket not empty.
- FLAGD, out, 1: OUT socket occupancy greater than WATERMARK.
- host_wr_valid / host_wr_ready / host_wr_data, in / out / 32: host-side stream that fills the OUT socket.
- host_rd_valid / host_rd_ready / host_rd_data / host_rd_last, out / in / 32 / 1: host-side stream that drains the IN socket.
- ovf_err / unf_err / addr_err, out, 1 each: sticky error flags.

Function
REQ-005 A bus write SHALL occur when SLCS=0, SLWR=0 and ADDR=00 at a clock edge; dq_in and ~PKEND are pushed as one 33-bit word into the IN socket.
REQ-006 A bus read SHALL occur when SLCS=0, SLRD=0 and ADDR=11; one word is popped from the OUT socket.
REQ-007 Read latency SHALL be exactly 2 cycles: the word popped at edge N appears on dq_out after edge N+2. The 2-stage pipeline advances every cycle.
REQ-008 When no read occurred at edge N, dq_out SHALL hold its previous value after edge N+2.
REQ-009 dq_oe SHALL be the registered value of (SLCS=0 and SLOE=0), i.e. 1-cycle latency.
REQ-010 A write to the full IN socket SHALL drop the word, leave the pointers unchanged and set ovf_err.
REQ-011 A read from the empty OUT socket SHALL leave the pointers unchanged, keep dq_out at its previous value and set unf_err.
REQ-012 Any active-low SLRD or SLWR with SLCS=0 SHALL set addr_err and perform no transfer in these cases:
- ADDR is 01 or 10;
- SLWR=0 with ADDR=11;
- SLRD=0 with ADDR=00.
REQ-013 SLRD=0 and SLWR=0 in the same cycle SHALL be handled per REQ-005, REQ-006 and REQ-012 for the current ADDR; at most one transfer occurs.
REQ-014 Host fill SHALL push host_wr_data into the OUT socket on host_wr_valid & host_wr_ready, with host_wr_ready = OUT socket not full (combinational from count).
REQ-015 Host drain SHALL pop the IN socket on host_rd_valid & host_rd_ready.
- host_rd_valid = IN socket not empty.
- host_rd_data and host_rd_last are presented from the head word with first-word-fall-through.
REQ-016 A push and a pop on the same socket in the same cycle SHALL both take effect; the occupancy is unchanged.
REQ-017 Pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; each occupancy counter SHALL be log2(DEPTH)+1 bits, ranging 0..DEPTH.
REQ-018 FLAGA..FLAGD SHALL be registered from the post-update occupancy, i.e. valid 1 cycle after the edge that changed the count.
REQ-019 Flag definitions:
- FLAGA = (in_cnt < DEPTH)
- FLAGB = (DEPTH - in_cnt > WATERMARK)
- FLAGC = (out_cnt > 0)
- FLAGD = (out_cnt > WATERMARK)
REQ-020 Error flags SHALL be sticky until reset.

Reset
REQ-021 When reset=1 at an edge, the block SHALL clear the following and start from that state on the next edge:
- both socket pointers and both counts;
- the read pipeline;
- dq_out = 0, dq_oe = 0;
- FLAGA..FLAGD = 0;
- host_rd_valid = 0, host_wr_ready = 0;
- ovf_err = unf_err = addr_err = 0.
REQ-022 Reset asserted mid-transfer SHALL discard all buffered words and in-flight pipeline data.
REQ-023 One cycle after reset deasserts, the flags SHALL read FLAGA=1, FLAGB=1, FLAGC=0, FLAGD=0.

Verification
REQ-024 Host pushes 0x100..0x107 (8 words); FPGA holds SLRD=0 at ADDR=11 for 8 cycles -> dq_out = 0x100..0x107 on consecutive cycles starting 2 cycles after the first read edge; FLAGC=0 one cycle after the last pop.
REQ-025 FPGA writes 32 words with PKEND=0 on the last word (DEPTH=32) -> FLAGA=0 and FLAGB=0. Host then drains -> 32 words in order, with host_rd_last=1 only on word 32. A 33rd write before draining sets ovf_err.
REQ-026 OUT socket holds 5 words, WATERMARK=4 -> FLAGD=1. One read -> FLAGD=0 on the next cycle; FLAGC stays 1.
REQ-027 Read at ADDR=01 -> addr_err=1, no pop. Read on the empty OUT socket -> unf_err=1, dq_out unchanged.
REQ-028 Assert reset after 3 words are buffered and a read is in the pipeline -> all outputs take their reset values; no stale word appears on dq_out afterwards.
REQ-029 Simultaneous host push and FPGA pop on the OUT socket at count 3 -> count stays 3 and the flags do not toggle; data order is preserved across the pointer wrap.
